// File: rtl/conv_mac_cin_acc.sv
// Multi-input-channel 3x3 conv MAC: tap products -> adder tree -> channel accumulator -> bias/shift/clip.
// Optional CONV_MAC_RELU_BYPASS_EN adds relu_en_i for a signed-saturating output mode.
module conv_mac_cin_acc #(
  parameter int DATA_RES    = 8,
  parameter int WEIGHT_RES  = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int NUM_CIN     = 4,
  parameter int FXP_SHIFT   = 4
) (
  input  logic                                        clk_i,
  input  logic                                        resetn_i,
  input  logic [DATA_RES*KERNEL_SIZE-1:0]             pixel_grid_i,
  input  logic [WEIGHT_RES*KERNEL_SIZE-1:0]           kernel_i,
  input  logic [WEIGHT_RES-1:0]                       bias_i,
`ifdef CONV_MAC_RELU_BYPASS_EN
  input  logic                                        relu_en_i,
`endif
  input  logic                                        in_valid_i,
  output logic                                        in_ready_o,
  output logic [DATA_RES-1:0]                         pixel_o,
  output logic                                        pixel_valid_o,
  input  logic                                        pixel_ready_i,
  output logic [((NUM_CIN > 1) ? $clog2(NUM_CIN) : 1)-1:0] cin_idx_o
);

  localparam int CIN_W  = (NUM_CIN > 1) ? $clog2(NUM_CIN) : 1;
  localparam int PROD_W = WEIGHT_RES + DATA_RES + 1;
  localparam int SUM_W  = PROD_W + $clog2(KERNEL_SIZE);
  localparam int ACC_W  = PROD_W + $clog2(KERNEL_SIZE * NUM_CIN) + 2;

  localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((2 ** DATA_RES) - 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (DATA_RES - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (DATA_RES - 1)));

  // Floor shift, then clamp to the unsigned (relu) or two's-complement output range.
  function automatic logic [DATA_RES-1:0] clip_px(input logic signed [ACC_W-1:0] a,
                                                  input logic relu);
    logic signed [ACC_W-1:0] r;
    r = a >>> FXP_SHIFT;
    if (relu) begin
      if (r[ACC_W-1])   r = '0;
      else if (r > UMAX) r = UMAX;
    end else begin
      if (r > SMAX)      r = SMAX;
      else if (r < SMIN) r = SMIN;
    end
    return r[DATA_RES-1:0];
  endfunction

  logic                     adv;
  logic                     accept;
  logic [CIN_W-1:0]         cin_cnt;
  logic                     first_beat;
  logic                     last_beat;

  logic signed [PROD_W-1:0] prod_c [KERNEL_SIZE];
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  acc_c;

  logic                     vld_p1, vld_p2, vld_p3;
  logic signed [PROD_W-1:0] prod_p1 [KERNEL_SIZE];
  logic signed [WEIGHT_RES-1:0] bias_p1, bias_p2;
  logic                     first_p1, first_p2;
  logic                     last_p1, last_p2;
  logic signed [SUM_W-1:0]  sum_p2;
  logic signed [ACC_W-1:0]  acc_p3;
  logic                     relu_grp;

  assign adv        = !pixel_valid_o | pixel_ready_i;
  assign in_ready_o = adv;
  assign accept     = in_valid_i & adv;
  assign first_beat = (cin_cnt == '0);
  assign last_beat  = (cin_cnt == CIN_W'(NUM_CIN - 1));
  assign cin_idx_o  = cin_cnt;

  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      prod_c[i] = $signed(kernel_i[i*WEIGHT_RES +: WEIGHT_RES])
                * $signed({1'b0, pixel_grid_i[i*DATA_RES +: DATA_RES]});
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      sum_c = sum_c + SUM_W'(prod_p1[i]);
    end
  end

  // Channel 0 restarts the accumulator with the bias, discarding any stale partial sum.
  always_comb begin
    if (first_p2) acc_c = ACC_W'(sum_p2) + (ACC_W'(bias_p2) <<< FXP_SHIFT);
    else          acc_c = acc_p3 + ACC_W'(sum_p2);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cin_cnt       <= '0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      vld_p3        <= 1'b0;
      pixel_valid_o <= 1'b0;
      pixel_o       <= '0;
    end else begin
      if (accept) cin_cnt <= last_beat ? '0 : cin_cnt + 1'b1;
      if (adv) begin
        vld_p1        <= in_valid_i;
        vld_p2        <= vld_p1;
        vld_p3        <= vld_p2 & last_p2;
        pixel_valid_o <= vld_p3;
        if (vld_p3) pixel_o <= clip_px(acc_p3, relu_grp);
      end
    end
  end

  // S1: products
  always_ff @(posedge clk_i) begin
    if (adv) begin
      prod_p1  <= prod_c;
      bias_p1  <= $signed(bias_i);
      first_p1 <= first_beat;
      last_p1  <= last_beat;
    end
  end

  // S2: tap sum
  always_ff @(posedge clk_i) begin
    if (adv) begin
      sum_p2   <= sum_c;
      bias_p2  <= bias_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
    end
  end

  // S3: channel accumulator
  always_ff @(posedge clk_i) begin
    if (adv && vld_p2) acc_p3 <= acc_c;
  end

`ifdef CONV_MAC_RELU_BYPASS_EN
  logic relu_p1, relu_p2, relu_p3;

  always_ff @(posedge clk_i) begin
    if (adv) begin
      relu_p1 <= relu_en_i;
      relu_p2 <= relu_p1;
      if (vld_p2 && first_p2) relu_p3 <= relu_p2;
    end
  end

  assign relu_grp = relu_p3;
`else
  assign relu_grp = 1'b1;
`endif

endmodule
